instr_fetch_buffer: RTL and testbench

Instruction fetch front end that consumes the program-counter address stream and returns instructions to decode. It issues word reads to instruction memory over a req/ack handshake, buffers returned instruction words with their PCs in a small FIFO, and presents them to the decoder on a valid/ready interface. A taken branch is signalled by `redirect`, which flushes the buffer and restarts fetch at the branch target.

---
 rtl/instr_fetch_buffer.sv | 145 ++++++++++++++
 tb/tb_instr_fetch_buffer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_buffer.sv
// Instruction fetch front end: single-outstanding word fetch, PC/instruction FIFO, redirect flush.
// Optional build macro IFB_PERF_CNT_EN adds the fetch_count accepted-instruction counter output.
module instr_fetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
`ifdef IFB_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;

    logic [1:0]    state_q;
    logic [31:0]   fetch_pc_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          mem_req_q;
    logic [31:0]   mem_addr_q;

    logic [31:0] data_mem [DEPTH];
    logic [31:0] pc_mem   [DEPTH];

    logic          push;
    logic          pop;
    logic [CW-1:0] count_after;
    logic [31:0]   redirect_tgt;
    logic [31:0]   next_pc;
    logic          unused_pc_bits;

    assign inst_valid     = (count_q != '0);
    // A redirect cancels any same-cycle FIFO traffic, so both strobes are qualified with it.
    assign pop            = inst_valid & inst_ready & ~redirect;
    assign push           = (state_q == S_REQ) & mem_ack & ~redirect;
    assign count_after    = count_q + CW'(1) - {{AW{1'b0}}, pop};
    assign redirect_tgt   = {redirect_pc[31:2], 2'b00};
    assign next_pc        = fetch_pc_q + 32'd4;
    assign unused_pc_bits = ^redirect_pc[1:0];

    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign inst_data = inst_valid ? data_mem[rd_ptr_q] : '0;
    assign inst_pc   = inst_valid ? pc_mem[rd_ptr_q]   : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            if (redirect) begin
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                count_q    <= '0;
                fetch_pc_q <= redirect_tgt;
            end else begin
                if (push) begin
                    wr_ptr_q   <= wr_ptr_q + AW'(1);
                    fetch_pc_q <= next_pc;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + AW'(1);
                end
                count_q <= count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            end

            case (state_q)
                S_IDLE: begin
                    if (!redirect && (count_q < DEPTH_C)) begin
                        state_q    <= S_REQ;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= fetch_pc_q;
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        if (!redirect && (count_after < DEPTH_C)) begin
                            mem_addr_q <= next_pc;
                        end else begin
                            state_q   <= S_IDLE;
                            mem_req_q <= 1'b0;
                        end
                    end else if (redirect) begin
                        // The bus request cannot be withdrawn; wait for its ack and drop the data.
                        state_q <= S_DISCARD;
                    end
                end
                S_DISCARD: begin
                    if (mem_ack) begin
                        state_q   <= S_IDLE;
                        mem_req_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && rst_n) begin
            data_mem[wr_ptr_q] <= mem_rdata;
            pc_mem[wr_ptr_q]   <= fetch_pc_q;
        end
    end

`ifdef IFB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_count <= '0;
        end else if (pop) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end
`else
    // Counter logic is absent in this build.
`endif

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Directed self-checking bench for instr_fetch_buffer; memory returns addr + 0x1000_0000.
// Perf-counter steps are compiled only when IFB_PERF_CNT_EN is defined.
module tb_instr_fetch_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;
`ifdef IFB_PERF_CNT_EN
    logic [31:0] fetch_count;
`endif

    logic zw;
    logic man_ack;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    // Zero-wait mode acks in the same cycle as the request; otherwise ack is driven by hand.
    assign mem_ack   = zw ? mem_req : man_ack;
    assign mem_rdata = mem_addr + 32'h1000_0000;

    instr_fetch_buffer #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .inst_valid  (inst_valid),
        .inst_data   (inst_data),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready)
`ifdef IFB_PERF_CNT_EN
        ,
        .fetch_count (fetch_count)
`endif
    );

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        inst_ready  = 1'b0;
        zw          = 1'b0;
        man_ack     = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int acks;
        int n;

        // Reset state
        do_reset();
        chk1("rst_mem_req", mem_req, 1'b0);
        chk32("rst_mem_addr", mem_addr, 32'h0);
        chk1("rst_inst_valid", inst_valid, 1'b0);
        chk32("rst_inst_data", inst_data, 32'h0);
        chk32("rst_inst_pc", inst_pc, 32'h0);

        // Zero-wait streaming, decoder always ready
        zw = 1'b1;
        inst_ready = 1'b1;
        tick();
        chk1("s_first_req", mem_req, 1'b1);
        chk32("s_first_addr", mem_addr, 32'h0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk1("s_valid", inst_valid, 1'b1);
            chk32("s_pc", inst_pc, 32'(4 * i));
            chk32("s_data", inst_data, 32'(4 * i) + 32'h1000_0000);
            chk32("s_addr", mem_addr, 32'(4 * (i + 1)));
        end

        // Decoder stalled: exactly DEPTH acks, then request drops
        do_reset();
        zw = 1'b1;
        tick();
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            if (mem_ack) acks++;
            tick();
        end
        chk32("full_acks", 32'(acks), 32'd4);
        chk1("full_req_low", mem_req, 1'b0);
        chk1("full_valid", inst_valid, 1'b1);
        chk32("full_head_pc", inst_pc, 32'h0);
        inst_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk32("drain_pc", inst_pc, 32'(4 * k));
            chk32("drain_data", inst_data, 32'(4 * k) + 32'h1000_0000);
            if (k == 1) chk1("drain_no_issue", mem_req, 1'b0);
            if (k == 2) begin
                chk1("resume_req", mem_req, 1'b1);
                chk32("resume_addr", mem_addr, 32'h10);
            end
        end

        // Redirect in IDLE with 3 buffered entries
        do_reset();
        zw = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) tick();
        zw = 1'b0;
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        chk1("r1_idle", mem_req, 1'b0);
        chk32("r1_head", inst_pc, 32'h4);
        redirect = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        chk1("r1_flush_valid", inst_valid, 1'b0);
        chk1("r1_no_req", mem_req, 1'b0);
        tick();
        chk1("r1_req", mem_req, 1'b1);
        chk32("r1_addr", mem_addr, 32'h100);

        // Redirect during an outstanding request to 0x20, acked three cycles later
        do_reset();
        zw = 1'b1;
        inst_ready = 1'b1;
        tick();
        n = 0;
        while (mem_addr !== 32'h20 && n < 40) begin
            tick();
            n++;
        end
        zw = 1'b0;
        man_ack = 1'b0;
        chk32("r2_reach_0x20", mem_addr, 32'h20);
        chk1("r2_pre_valid", inst_valid, 1'b1);
        redirect = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect = 1'b0;
        chk1("r2_flush_valid", inst_valid, 1'b0);
        chk1("r2_held_req", mem_req, 1'b1);
        chk32("r2_held_addr", mem_addr, 32'h20);
        tick();
        chk32("r2_held_addr2", mem_addr, 32'h20);
        tick();
        chk1("r2_held_req3", mem_req, 1'b1);
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        chk1("r2_after_ack_req", mem_req, 1'b0);
        chk1("r2_dropped", inst_valid, 1'b0);
        tick();
        chk1("r2_new_req", mem_req, 1'b1);
        chk32("r2_new_addr", mem_addr, 32'h200);
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        chk1("r2_deliver_valid", inst_valid, 1'b1);
        chk32("r2_deliver_pc", inst_pc, 32'h200);
        chk32("r2_deliver_data", inst_data, 32'h1000_0200);

        // Redirect to 0x303 coincident with ack of 0x204
        chk32("r3_pending_addr", mem_addr, 32'h204);
        man_ack = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h303;
        tick();
        man_ack = 1'b0;
        redirect = 1'b0;
        chk1("r3_flush_valid", inst_valid, 1'b0);
        chk1("r3_idle", mem_req, 1'b0);
        tick();
        chk1("r3_req", mem_req, 1'b1);
        chk32("r3_addr", mem_addr, 32'h300);
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        chk32("r3_pc", inst_pc, 32'h300);
        chk32("r3_data", inst_data, 32'h1000_0300);

        // Reset mid-transaction overrides a redirect and in-flight request
        zw = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h500;
        tick();
        chk1("mr_req", mem_req, 1'b0);
        chk32("mr_addr", mem_addr, 32'h0);
        chk1("mr_valid", inst_valid, 1'b0);
        chk32("mr_data", inst_data, 32'h0);
        chk32("mr_pc", inst_pc, 32'h0);
        rst_n = 1'b1;
        redirect = 1'b0;
        tick();
        chk1("mr_restart_req", mem_req, 1'b1);
        chk32("mr_restart_addr", mem_addr, 32'h0);

`ifdef IFB_PERF_CNT_EN
        do_reset();
        chk32("pc_reset", fetch_count, 32'h0);
        zw = 1'b1;
        inst_ready = 1'b1;
        acks = 0;
        n = 0;
        while (acks < 10 && n < 100) begin
            if (inst_valid) acks++;
            tick();
            n++;
        end
        chk1("pc_stream_valid", inst_valid, 1'b1);
        redirect = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect = 1'b0;
        chk32("pc_count10", fetch_count, 32'd10);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        chk32("pc_midrst", fetch_count, 32'h0);
        chk1("pc_midrst_valid", inst_valid, 1'b0);
        rst_n = 1'b1;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
